// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus shared between the requesters, the arbiter and the FIFO.
// The arbiter sits on the slave modport; the requester/FIFO side uses master.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic                   full;
    logic [NREQ-1:0]        ack;
    logic                   w_en;
    logic [DWIDTH-1:0]      data_in;
    logic [GW-1:0]          grant_id;
    logic                   busy;

    modport master (
        output req, req_data, full,
        input  ack, w_en, data_in, grant_id, busy
    );

    modport slave (
        input  req, req_data, full,
        output ack, w_en, data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side.
// Each grant is a burst of up to MAX_BURST beats; the datapath is
// combinational, while grant, beat count and priority pointer are registered.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              w_clk,
    input  logic              w_rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_q, beat_d;

    logic          arb_found;
    logic [GW-1:0] arb_idx;
    logic [GW-1:0] cand_idx;
    int            cand;

    logic          in_burst;
    logic          req_g;
    logic          ack_g;
    logic          last_beat;
    logic [GW-1:0] rr_after_g;

    // Pick the first requester at or above rr_ptr, wrapping modulo NREQ
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[GW-1:0];
            if (!arb_found && bus.req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Zero-latency write datapath; reset forces every output quiet
    always_comb begin
        in_burst   = (state_q == BURST);
        req_g      = bus.req[grant_q];
        ack_g      = in_burst & req_g & ~bus.full & ~w_rst;
        last_beat  = (beat_q == CW'(MAX_BURST - 1));
        rr_after_g = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

        bus.ack          = '0;
        bus.ack[grant_q] = ack_g;
        bus.w_en         = ack_g;
        bus.data_in      = '0;
        if (in_burst && !w_rst) begin
            bus.data_in = bus.req_data[grant_q*DWIDTH +: DWIDTH];
        end
        bus.busy     = in_burst & ~w_rst;
        bus.grant_id = w_rst ? '0 : grant_q;
    end

    // Arbitration in IDLE, beat counting and burst termination in BURST
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BURST;
                    grant_d = arb_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (!req_g) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_after_g;
                end else if (ack_g) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_after_g;
                    end
                end
            end
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. It shares the FIFO write side (w_en/data_in, back-pressured by full) among NREQ requesters in the write clock domain. Each grant is a burst of up to MAX_BURST beats, which bounds latency for the other requesters. The datapath is combinational and zero-latency; control (grant, burst count, priority pointer) is registered.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DWIDTH, 8: data width; must match the FIFO DWIDTH.
- MAX_BURST, 4: maximum beats per grant, 1..16.

- w_clk  in  1  write-domain clock, rising edge.
- w_rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request[i]; held high while requester i has a beat to present.
- req_data  in  NREQ*DWIDTH  requester i data in slice [i*DWIDTH +: DWIDTH]; stable while req[i] is high.
- full  in  1  FIFO write-side full flag.
- ack  out  NREQ  one-hot; ack[i]=1 means requester i's beat is written at this rising edge.
- w_en  out  1  FIFO write enable; equals |ack.
- data_in  out  DWIDTH  FIFO write data; the granted requester's slice when in BURST, else 0.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.
- busy  out  1  high in the BURST state.

## Operation
- State register values: state, grant_id, rr_ptr, beat_cnt.
- Values under reset, and for the cycle w_rst is sampled high:
  - state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0.
  - ack=0, w_en=0, data_in=0, busy=0.
  - While w_rst is high, ack and w_en are forced to 0 combinationally.
- IDLE:
  - If req != 0, grant the first i with req[i]=1, searching upward from rr_ptr with wrap modulo NREQ.
  - Then: grant_id<=i, beat_cnt<=0, state<=BURST.
  - No beat transfers in IDLE.
- BURST with g=grant_id:
  - ack[g] = req[g] & ~full; all other ack bits are 0.
  - On each ack edge, beat_cnt<=beat_cnt+1.
  - Exit to IDLE with rr_ptr<=(g+1) mod NREQ when either condition holds:
    - ack and beat_cnt==MAX_BURST-1 (last beat), or
    - req[g]==0 (early release, no beat that cycle).
  - full=1 with req[g]=1: stall. Grant held, no beat, beat_cnt unchanged, no timeout.
  - full=1 with req[g]=0: release, as for early release.
- beat_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 while in BURST.
- rr_ptr wraps NREQ-1 -> 0. The pointer search uses modulo NREQ, also for non-power-of-2 NREQ.
- Requests from non-granted requesters are ignored until the next IDLE arbitration. Requests are never dropped or reordered within one requester.

## Timing
- Request to first beat: req rises in cycle t with the arbiter in IDLE -> grant registered at edge t -> first ack/w_en in cycle t+1 (if full=0).
- Beats inside a burst are on consecutive cycles when full=0. Throughput is MAX_BURST beats per MAX_BURST+1 cycles under continuous load (one IDLE bubble per burst).
- Handshake:
  - The requester samples ack at the rising edge.
  - On an ack edge, the requester either advances req_data to its next beat or drops req.
- full is sampled in the same cycle as w_en. The arbiter relies on the FIFO updating full at the write edge, so no beat is issued while full=1.
- w_en and data_in are combinational from registered state, req, req_data and full. The FIFO registers them at the same w_clk edge.

## Test plan
- Reset: hold w_rst=1 for 2 cycles with req=4'b1111 -> ack=0, w_en=0, data_in=0, busy=0, grant_id=0 throughout. The first grant after release goes to requester 0.
- Single requester: req=4'b0001, data A1..A6 advanced on ack -> w_en pulses carry A1,A2,A3,A4 on consecutive cycles, then 1 idle cycle, then A5,A6. grant_id stays 0.
- All four requesting continuously -> bursts of 4 beats, grant order 0,1,2,3,0, exactly one w_en=0 cycle between bursts. Each ack is one-hot and matches grant_id.
- Back-pressure: full=1 for 3 cycles after beat 2 of a burst -> w_en=0 for those 3 cycles, busy=1, grant held. Beats 3 and 4 follow once full=0, 4 beats total, none lost or duplicated.
- Early release: requester 2 drops req after 1 beat while 0, 1 and 3 are requesting -> return to IDLE; the next grant goes to 3 (rr_ptr=3), then 0.
- Reset mid-burst: assert w_rst during beat 2 of requester 1's burst -> w_en=0 in that cycle, all registers cleared. After release with req=4'b0010, requester 1 gets a full new burst of 4 beats.
